// File: rtl/wasm_const_decoder_pkg.sv
// Shared constants for the WebAssembly constant-instruction decoder:
// opcode values, result-type and trap encodings, LEB128 length limits.
package wasm_const_decoder_pkg;

  localparam logic [7:0] OP_I32_CONST = 8'h41;
  localparam logic [7:0] OP_I64_CONST = 8'h42;
  localparam logic [7:0] OP_F32_CONST = 8'h43;
  localparam logic [7:0] OP_F64_CONST = 8'h44;

  typedef enum logic [1:0] {
    RT_I32 = 2'd0,
    RT_I64 = 2'd1,
    RT_F32 = 2'd2,
    RT_F64 = 2'd3
  } result_type_e;

  typedef enum logic [3:0] {
    TRAP_NONE       = 4'd0,
    TRAP_BAD_OPCODE = 4'd1,
    TRAP_LEB_LONG   = 4'd2
  } trap_e;

  localparam int unsigned LEB_MAX32_DEF = 5;
  localparam int unsigned LEB_MAX64_DEF = 10;

  // 64-bit opcodes are only decodable when the stack word is 64 bits wide.
  function automatic logic opcode_legal(input logic [7:0] op, input int unsigned width);
    case (op)
      OP_I32_CONST, OP_F32_CONST: return 1'b1;
      OP_I64_CONST, OP_F64_CONST: return (width == 64);
      default:                    return 1'b0;
    endcase
  endfunction

  function automatic result_type_e opcode_type(input logic [7:0] op);
    case (op)
      OP_I64_CONST: return RT_I64;
      OP_F32_CONST: return RT_F32;
      OP_F64_CONST: return RT_F64;
      default:      return RT_I32;
    endcase
  endfunction

endpackage

// File: rtl/wasm_const_decoder_leb128_acc.sv
// Signed LEB128 accumulate step: merges one byte's 7-bit payload at
// position 7*cnt, sign-fills on the terminating byte and flags overlong
// encodings. Purely combinational; the FSM owns the registers.
module leb128_acc #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned CW        = 4,
  parameter int unsigned LEB_MAX32 = 5,
  parameter int unsigned LEB_MAX64 = 10
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [CW-1:0]    cnt,
  input  logic [7:0]       byte_in,
  input  logic             is_i32,
  output logic [WIDTH-1:0] acc_next,
  output logic             last,
  output logic             too_long
);

  logic [WIDTH-1:0] payload;
  logic [WIDTH-1:0] fill;
  logic [WIDTH-1:0] type_mask;
  int unsigned      sh;
  int unsigned      max_len;

  // Payload bits shifted past WIDTH fall off; i32 is then clipped to 32 bits
  // so any excess payload or sign fill above bit 31 reads as zero.
  always_comb begin
    sh        = 7 * 32'(cnt);
    max_len   = is_i32 ? LEB_MAX32 : LEB_MAX64;
    payload   = WIDTH'(byte_in[6:0]) << sh;
    fill      = '0;
    if (!byte_in[7] && byte_in[6])
      fill = {WIDTH{1'b1}} << (sh + 7);
    type_mask = is_i32 ? WIDTH'(32'hFFFF_FFFF) : {WIDTH{1'b1}};
    acc_next  = (acc | payload | fill) & type_mask;
    last      = !byte_in[7];
    too_long  = byte_in[7] && (32'(cnt) == max_len - 1);
  end

endmodule

// File: rtl/wasm_const_decoder.sv
// Byte-serial decoder for i32/i64/f32/f64.const immediates. Floats are
// assembled little-endian inline; integers go through leb128_acc. One
// result per instruction via valid/ready, sticky trap on malformed input.
module wasm_const_decoder
  import wasm_const_decoder_pkg::*;
#(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned LEB_MAX32 = LEB_MAX32_DEF,
  parameter int unsigned LEB_MAX64 = LEB_MAX64_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       opcode,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       result_type,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             busy,
  output logic [3:0]       trap
);

  localparam int unsigned CW = $clog2(LEB_MAX64 + 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE, S_TRAP} state_e;

  state_e           state;
  result_type_e     rtype;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;

  logic             is_float;
  logic             float_last;
  logic [WIDTH-1:0] float_next;
  logic [WIDTH-1:0] leb_next;
  logic             leb_last;
  logic             leb_too_long;

  leb128_acc #(
    .WIDTH     (WIDTH),
    .CW        (CW),
    .LEB_MAX32 (LEB_MAX32),
    .LEB_MAX64 (LEB_MAX64)
  ) u_leb (
    .acc      (acc),
    .cnt      (cnt),
    .byte_in  (byte_in),
    .is_i32   (rtype == RT_I32),
    .acc_next (leb_next),
    .last     (leb_last),
    .too_long (leb_too_long)
  );

  // Little-endian float assembly: byte cnt lands at bit 8*cnt.
  always_comb begin
    is_float   = (rtype == RT_F32) || (rtype == RT_F64);
    float_next = acc | (WIDTH'(byte_in) << (8 * 32'(cnt)));
    float_last = (cnt == ((rtype == RT_F64) ? CW'(7) : CW'(3)));
  end

  // Control FSM; every output is registered so it changes only on an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      rtype        <= RT_I32;
      cnt          <= '0;
      acc          <= '0;
      byte_ready   <= 1'b0;
      result       <= '0;
      result_type  <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      trap         <= TRAP_NONE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (opcode_legal(opcode, WIDTH)) begin
              state      <= S_FETCH;
              cnt        <= '0;
              acc        <= '0;
              rtype      <= opcode_type(opcode);
              byte_ready <= 1'b1;
            end else begin
              state <= S_TRAP;
              trap  <= TRAP_BAD_OPCODE;
            end
          end
        end
        S_FETCH: begin
          if (byte_valid) begin
            cnt <= cnt + CW'(1);
            if (is_float) begin
              acc <= float_next;
              if (float_last) begin
                state        <= S_DONE;
                byte_ready   <= 1'b0;
                result       <= float_next;
                result_type  <= rtype;
                result_valid <= 1'b1;
              end
            end else begin
              acc <= leb_next;
              if (leb_last) begin
                state        <= S_DONE;
                byte_ready   <= 1'b0;
                result       <= leb_next;
                result_type  <= rtype;
                result_valid <= 1'b1;
              end else if (leb_too_long) begin
                state      <= S_TRAP;
                byte_ready <= 1'b0;
                trap       <= TRAP_LEB_LONG;
              end
            end
          end
        end
        S_DONE: begin
          if (result_ready) begin
            state        <= S_IDLE;
            result_valid <= 1'b0;
            busy         <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wasm_const_decoder.sv
// Directed bench for wasm_const_decoder: hand-computed vectors for each
// constant type, LEB traps, backpressure, async reset and the 32-bit build.
module tb_wasm_const_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  opcode;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [63:0] result;
  logic [1:0]  result_type;
  logic        result_valid;
  logic        result_ready;
  logic        busy;
  logic [3:0]  trap;

  logic        start32;
  logic        byte_ready32;
  logic [31:0] result32;
  logic [1:0]  result_type32;
  logic        result_valid32;
  logic        busy32;
  logic [3:0]  trap32;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wasm_const_decoder #(.WIDTH(64), .LEB_MAX32(5), .LEB_MAX64(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .opcode       (opcode),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .result       (result),
    .result_type  (result_type),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy),
    .trap         (trap)
  );

  wasm_const_decoder #(.WIDTH(32), .LEB_MAX32(5), .LEB_MAX64(10)) dut32 (
    .clk          (clk),
    .reset        (reset),
    .start        (start32),
    .opcode       (opcode),
    .byte_in      (8'h00),
    .byte_valid   (1'b0),
    .byte_ready   (byte_ready32),
    .result       (result32),
    .result_type  (result_type32),
    .result_valid (result_valid32),
    .result_ready (1'b0),
    .busy         (busy32),
    .trap         (trap32)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] op);
    opcode = op;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    int k;
    k = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready && k < 16) begin
      @(posedge clk); #1;
      k++;
    end
    if (!byte_ready) check_eq("byte_ready_timeout", 64'(byte_ready), 64'd1);
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic pop(input string tag);
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    check_eq({tag, "_valid_drop"}, 64'(result_valid), 64'd0);
    check_eq({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; start32 = 1'b0; opcode = 8'h00;
    byte_in = 8'h00; byte_valid = 1'b0; result_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_result", result, 64'd0);
    check_eq("rst_valid", 64'(result_valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_ready", 64'(byte_ready), 64'd0);
    check_eq("rst_trap", 64'(trap), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // f32.const 00 00 00 c0 with a two-cycle stall mid-stream
    do_start(8'h43);
    check_eq("f32_busy", 64'(busy), 64'd1);
    check_eq("f32_byte_ready", 64'(byte_ready), 64'd1);
    push(8'h00); push(8'h00);
    repeat (2) @(posedge clk);
    #1;
    check_eq("f32_stall_valid", 64'(result_valid), 64'd0);
    push(8'h00);
    check_eq("f32_early_valid", 64'(result_valid), 64'd0);
    push(8'hc0);
    check_eq("f32_valid", 64'(result_valid), 64'd1);
    check_eq("f32_result", result, 64'h00000000_c0000000);
    check_eq("f32_type", 64'(result_type), 64'd2);
    check_eq("f32_trap", 64'(trap), 64'd0);
    check_eq("f32_ready_low", 64'(byte_ready), 64'd0);
    pop("f32");

    // i32.const 7f -> -1
    do_start(8'h41);
    push(8'h7f);
    check_eq("i32_m1_valid", 64'(result_valid), 64'd1);
    check_eq("i32_m1_result", result, 64'h00000000_ffffffff);
    check_eq("i32_m1_type", 64'(result_type), 64'd0);
    pop("i32_m1");

    // i32.const 80 80 80 80 08 -> 0x80000000 (5-byte maximum)
    do_start(8'h41);
    push(8'h80); push(8'h80); push(8'h80); push(8'h80); push(8'h08);
    check_eq("i32_min_result", result, 64'h00000000_80000000);
    check_eq("i32_min_trap", 64'(trap), 64'd0);
    pop("i32_min");

    // i64.const e5 8e 26 -> 0x98765
    do_start(8'h42);
    push(8'he5); push(8'h8e); push(8'h26);
    check_eq("i64_pos_result", result, 64'h00000000_00098765);
    check_eq("i64_pos_type", 64'(result_type), 64'd1);
    pop("i64_pos");

    // i64.const 7f -> -1
    do_start(8'h42);
    push(8'h7f);
    check_eq("i64_m1_result", result, 64'hffffffff_ffffffff);
    pop("i64_m1");

    // i64.const with ten continuation bytes -> LEB too long
    do_start(8'h42);
    for (int i = 0; i < 9; i++) push(8'h80);
    check_eq("leb9_trap", 64'(trap), 64'd0);
    push(8'h80);
    check_eq("leb_trap", 64'(trap), 64'd2);
    check_eq("leb_valid", 64'(result_valid), 64'd0);
    check_eq("leb_ready", 64'(byte_ready), 64'd0);
    check_eq("leb_busy", 64'(busy), 64'd1);
    do_start(8'h43);
    repeat (3) @(posedge clk);
    #1;
    check_eq("leb_trap_held", 64'(trap), 64'd2);
    check_eq("leb_busy_held", 64'(busy), 64'd1);
    reset = 1'b1; #2;
    check_eq("leb_trap_clear", 64'(trap), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // invalid opcode 0x45
    do_start(8'h45);
    check_eq("badop_trap", 64'(trap), 64'd1);
    check_eq("badop_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;

    // f64.const 1.0 with result_ready held low and start pulsed in DONE
    do_start(8'h44);
    push(8'h00); push(8'h00); push(8'h00); push(8'h00);
    push(8'h00); push(8'h00); push(8'hf0); push(8'h3f);
    check_eq("f64_valid", 64'(result_valid), 64'd1);
    check_eq("f64_result", result, 64'h3ff00000_00000000);
    check_eq("f64_type", 64'(result_type), 64'd3);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        opcode = 8'h43;
        start  = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      check_eq("f64_hold_result", result, 64'h3ff00000_00000000);
      check_eq("f64_hold_valid", 64'(result_valid), 64'd1);
    end
    pop("f64");
    check_eq("f64_start_ignored", 64'(byte_ready), 64'd0);

    // async reset two bytes into an f64
    do_start(8'h44);
    push(8'h11); push(8'h22);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_result", result, 64'd0);
    check_eq("arst_busy", 64'(busy), 64'd0);
    check_eq("arst_ready", 64'(byte_ready), 64'd0);
    check_eq("arst_type", 64'(result_type), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // f32.const 1.0 after the reset: no leftover partial value
    do_start(8'h43);
    push(8'h00); push(8'h00); push(8'h80); push(8'h3f);
    check_eq("f32b_result", result, 64'h00000000_3f800000);
    pop("f32b");

    // 32-bit build rejects i64.const
    opcode  = 8'h42;
    start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    check_eq("w32_trap", 64'(trap32), 64'd1);
    check_eq("w32_busy", 64'(busy32), 64'd1);
    check_eq("w32_ready", 64'(byte_ready32), 64'd0);
    check_eq("w32_valid", 64'(result_valid32), 64'd0);
    check_eq("w32_result", 64'(result32), 64'd0);
    check_eq("w32_type", 64'(result_type32), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
